// File: rtl/post_pkg.sv
// Purpose: shared constants, state encodings and seven-segment helpers for the post-level period timer.
// Latency: not applicable, this file holds no logic.
// Backpressure: not applicable, this file holds no logic.
// Ports: none.
package post_pkg;

  // Segments are active-low. Bit 7 is the decimal point, which is always off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} conv_state_t;

  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Used at elaboration time to size the saturation threshold.
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/post_period_timer_if.sv
// Purpose: groups the start, abort and count inputs with the status and display outputs of the timer.
// Latency: not applicable, this file holds wiring only.
// Backpressure: none; every signal is sampled or driven every cycle.
// Ports: master drives postSig, abort and magicSymbolCount; slave drives levelComplete, running, secsLeft and postSeg.
interface post_period_timer_if #(
  parameter int COUNT_W    = 8,
  parameter int NUM_DIGITS = 4
) ();
  logic                    postSig;
  logic                    abort;
  logic [COUNT_W-1:0]      magicSymbolCount;
  logic                    levelComplete;
  logic                    running;
  logic [7:0]              secsLeft;
  logic [8*NUM_DIGITS-1:0] postSeg;

  modport master (
    output postSig, abort, magicSymbolCount,
    input  levelComplete, running, secsLeft, postSeg
  );

  modport slave (
    input  postSig, abort, magicSymbolCount,
    output levelComplete, running, secsLeft, postSeg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential shift/add-3 binary-to-BCD converter with an out-of-range flag.
// Latency: value is sampled on the start edge; bcd and sat are valid while done is high, IN_W+1 cycles later.
// Backpressure: start is ignored while busy; done is a single-cycle strobe with no hold-off.
// Ports: Clk100M, Rst_n; start/value in; busy, done, bcd (DIGITS nibbles, digit 0 in the low nibble), sat out.
module bin2bcd_seq
  import post_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 4
) (
  input  logic                  Clk100M,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sat
);

  // Every IN_W-bit value fits in ceil(IN_W/3) decimal digits, because 8^k <= 10^k.
  // The working register holds at least that many digits, so that values too wide
  // for the display still convert cleanly before sat overrides them.
  localparam int NAT_D = (IN_W + 2) / 3;
  localparam int INT_D = (NAT_D > DIGITS) ? NAT_D : DIGITS;
  localparam int BW    = 4 * INT_D;
  localparam int CNT_W = $clog2(IN_W);
  localparam int unsigned LIMIT = pow10(DIGITS);

  conv_state_t      st_q, st_d;
  logic [IN_W-1:0]  bin_q;
  logic [BW-1:0]    bcd_q, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             last_step;

  assign last_step = (cnt_q == CNT_W'(IN_W - 1));

  always_comb begin
    st_d = st_q;
    case (st_q)
      CV_IDLE:  if (start) st_d = CV_SHIFT;
      CV_SHIFT: if (last_step) st_d = CV_DONE;
      CV_DONE:  st_d = CV_IDLE;
      default:  st_d = CV_IDLE;
    endcase
  end

  // Add 3 to any digit of 5 or more before the shift, so it carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < INT_D; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_nxt = (bcd_adj << 1) | BW'(bin_q[IN_W-1]);
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q  <= CV_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == CV_IDLE && start) begin
        bin_q <= value;
        bcd_q <= '0;
        cnt_q <= '0;
        sat_q <= (32'(value) >= LIMIT);
      end else if (st_q == CV_SHIFT) begin
        bcd_q <= bcd_nxt;
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy = (st_q != CV_IDLE);
  assign done = (st_q == CV_DONE);
  assign bcd  = bcd_q[4*DIGITS-1:0];
  assign sat  = sat_q;

endmodule

// File: rtl/post_period_timer.sv
// Purpose: runs a post-level period of PERIOD_SEC seconds after a start pulse and shows a decimal count on seven-segment digits.
// Latency: levelComplete fires PERIOD_SEC*TICK_DIV cycles after the start edge; a count change reaches postSeg within 2*(COUNT_W+2) cycles.
// Backpressure: none; postSig during a running period is ignored, and abort beats postSig.
// Ports: Clk100M, Rst_n; bus (slave) carries postSig, abort, magicSymbolCount in and levelComplete, running, secsLeft, postSeg out.
module post_period_timer
  import post_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int PERIOD_SEC = 5,
  parameter int COUNT_W    = 8,
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_LZ   = 0
) (
  input  logic               Clk100M,
  input  logic               Rst_n,
  post_period_timer_if.slave bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);

  state_t                  state_q, state_d;
  logic [PRESC_W-1:0]      presc_q;
  logic [7:0]              secs_q;
  logic                    lc_q;
  logic                    tick;
  logic                    start_run;

  logic                    conv_busy, conv_done, conv_sat;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [4*NUM_DIGITS-1:0] bcd_latch;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    nz_seen;

  assign tick = (state_q == RUN) && (presc_q == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.postSig && !bus.abort) state_d = RUN;
      RUN: begin
        if (bus.abort) state_d = IDLE;
        else if (tick && secs_q == 8'd1) state_d = DONE;
      end
      DONE: begin
        if (bus.abort) state_d = IDLE;
        else if (bus.postSig) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_run = (state_q != RUN) && (state_d == RUN);

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      secs_q  <= '0;
      lc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= (state_q == RUN) && (state_d == DONE);

      // A fresh start clears the prescaler so the first second is a full TICK_DIV cycles.
      if (start_run || state_d != RUN) presc_q <= '0;
      else if (tick) presc_q <= '0;
      else presc_q <= presc_q + PRESC_W'(1);

      if (start_run) secs_q <= 8'(PERIOD_SEC);
      else if (state_d != RUN) secs_q <= '0;
      else if (tick && secs_q != 8'd0) secs_q <= secs_q - 8'd1;
    end
  end

  // The converter restarts as soon as it goes idle, so the latch tracks the count continuously.
  bin2bcd_seq #(
    .IN_W   (COUNT_W),
    .DIGITS (NUM_DIGITS)
  ) u_bcd (
    .Clk100M (Clk100M),
    .Rst_n   (Rst_n),
    .start   (!conv_busy),
    .value   (bus.magicSymbolCount),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .sat     (conv_sat)
  );

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      bcd_latch <= '0;
    end else if (conv_done) begin
      bcd_latch <= conv_sat ? {NUM_DIGITS{4'd9}} : conv_bcd;
    end
  end

  // Walk from the top digit down: once a non-zero digit has been seen, every lower digit is shown.
  always_comb begin
    seg_d   = '1;
    nz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_seen = nz_seen | (bcd_latch[4*i +: 4] != 4'd0);
      if (state_q != IDLE) begin
        if (BLANK_LZ != 0 && i != 0 && !nz_seen) seg_d[8*i +: 8] = SEG_BLANK;
        else seg_d[8*i +: 8] = seg_of_digit(bcd_latch[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) seg_q <= '1;
    else seg_q <= seg_d;
  end

  assign bus.levelComplete = lc_q;
  assign bus.running       = (state_q == RUN);
  assign bus.secsLeft      = secs_q;
  assign bus.postSeg       = seg_q;

endmodule
